// File: rtl/tetris_pkg.sv
// Shared Tetris board constants: board geometry, colour width/codes,
// cell-address width, FSM state encoding and the cell-address helper.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int COLOR_W = 3;
    localparam int ADDR_W  = 8;

    typedef enum logic [COLOR_W-1:0] {
        CLR_EMPTY  = 3'd0,
        CLR_CYAN   = 3'd1,
        CLR_BLUE   = 3'd2,
        CLR_ORANGE = 3'd3,
        CLR_YELLOW = 3'd4,
        CLR_GREEN  = 3'd5,
        CLR_PURPLE = 3'd6,
        CLR_RED    = 3'd7
    } color_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } game_st_e;

    // Linear cell address: row-major, one word per cell.
    function automatic logic [ADDR_W-1:0] cell_addr(input int row, input int col, input int w);
        return ADDR_W'(row * w + col);
    endfunction

endpackage

// File: rtl/tetris_cell_map.sv
// Pixel-to-cell mapping: board window test, cell col/row, and the fetch slot
// (first pixel of each cell column).
module tetris_cell_map
    import tetris_pkg::*;
#(
    parameter int BOARD_W = tetris_pkg::BOARD_W,
    parameter int BOARD_H = tetris_pkg::BOARD_H,
    parameter int CELL_PX = 16,
    parameter int ORG_X   = 320,
    parameter int ORG_Y   = 80
) (
    input  logic              de,
    input  logic [9:0]        active_x,
    input  logic [9:0]        active_y,
    output logic              in_win,
    output logic              fetch,
    output logic [ADDR_W-1:0] addr
);

    int dx;
    int dy;

    // Window test and cell address; offsets are signed so left/above is rejected.
    always_comb begin
        dx     = int'(active_x) - ORG_X;
        dy     = int'(active_y) - ORG_Y;
        in_win = de && (dx >= 0) && (dx < BOARD_W * CELL_PX)
                    && (dy >= 0) && (dy < BOARD_H * CELL_PX);
        fetch  = in_win && ((dx % CELL_PX) == 0);
        addr   = in_win ? cell_addr(dy / CELL_PX, dx / CELL_PX, BOARD_W) : '0;
    end

endmodule

// File: rtl/tetris_board_arb.sv
// Board RAM arbiter: display fetch owns the single-port RAM on fetch
// pixels; game logic gets the remaining cycles through a small FSM.
// Optional build macro BOARD_ARB_BLANK_ONLY_EN restricts game grants to
// blanking (de=0) cycles.
module tetris_board_arb
    import tetris_pkg::*;
#(
    parameter int BOARD_W = tetris_pkg::BOARD_W,
    parameter int BOARD_H = tetris_pkg::BOARD_H,
    parameter int CELL_PX = 16,
    parameter int ORG_X   = 320,
    parameter int ORG_Y   = 80
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de,
    input  logic [9:0]         active_x,
    input  logic [9:0]         active_y,
    input  logic               game_req,
    input  logic               game_we,
    input  logic [3:0]         game_col,
    input  logic [4:0]         game_row,
    input  logic [COLOR_W-1:0] game_wdata,
    output logic               game_gnt,
    output logic [COLOR_W-1:0] game_rdata,
    output logic               game_rvalid,
    output logic               ram_en,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [COLOR_W-1:0] ram_wdata,
    input  logic [COLOR_W-1:0] ram_rdata,
    output logic               pix_valid,
    output logic [COLOR_W-1:0] pix_color
);

    localparam int STAGES = 2;

    logic              in_win;
    logic              fetch;
    logic [ADDR_W-1:0] disp_addr;
    logic              gnt_ok;
    logic              oor;
    logic              oor_q;
    logic [COLOR_W-1:0] rd_now;
    logic [COLOR_W-1:0] rdata_q;
    logic [COLOR_W-1:0] last_color;
    logic              fetch_d1;
    logic [STAGES:1]   vld_pipe;
    game_st_e          state;

    tetris_cell_map #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .CELL_PX (CELL_PX),
        .ORG_X   (ORG_X),
        .ORG_Y   (ORG_Y)
    ) u_map (
        .de       (de),
        .active_x (active_x),
        .active_y (active_y),
        .in_win   (in_win),
        .fetch    (fetch),
        .addr     (disp_addr)
    );

`ifdef BOARD_ARB_BLANK_ONLY_EN
    assign gnt_ok = !fetch && !de;
`else
    assign gnt_ok = !fetch;
`endif

    assign oor    = (int'(game_col) >= BOARD_W) || (int'(game_row) >= BOARD_H);
    assign rd_now = oor_q ? '0 : ram_rdata;

    // RAM port mux: display first, then a pending game access; quiet in reset.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        game_gnt  = 1'b0;
        if (rst_n) begin
            if (fetch) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end else if (state == ACCESS && gnt_ok) begin
                game_gnt = 1'b1;
                if (!oor) begin
                    ram_en    = 1'b1;
                    ram_we    = game_we;
                    ram_addr  = cell_addr(int'(game_row), int'(game_col), BOARD_W);
                    ram_wdata = game_we ? game_wdata : '0;
                end
            end
        end
    end

    // Read data is returned combinationally in RDWAIT (RAM latency is one
    // cycle) and held in rdata_q afterwards.
    assign game_rvalid = (state == RDWAIT);
    assign game_rdata  = (state == RDWAIT) ? rd_now : rdata_q;

    // Game access FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            oor_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (game_req) state <= ACCESS;
                ACCESS: if (game_gnt) begin
                    state <= game_we ? IDLE : RDWAIT;
                    oor_q <= oor;
                end
                RDWAIT: begin
                    state   <= IDLE;
                    rdata_q <= rd_now;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel pipeline: stage 1 issues the read, stage 2 captures RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            fetch_d1   <= 1'b0;
            last_color <= '0;
            pix_color  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_win};
            fetch_d1 <= fetch;
            if (fetch_d1) last_color <= ram_rdata;
            pix_color <= vld_pipe[1] ? (fetch_d1 ? ram_rdata : last_color) : '0;
        end
    end

    assign pix_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_tetris_board_arb.sv
// Directed bench for tetris_board_arb with a behavioural 1-cycle-latency RAM.
module tb_tetris_board_arb;

    localparam int ORG_X = 320;
    localparam int ORG_Y = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de = 1'b0;
    logic [9:0] active_x = '0;
    logic [9:0] active_y = '0;
    logic       game_req = 1'b0;
    logic       game_we = 1'b0;
    logic [3:0] game_col = '0;
    logic [4:0] game_row = '0;
    logic [2:0] game_wdata = '0;
    logic       game_gnt;
    logic [2:0] game_rdata;
    logic       game_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata = '0;
    logic       pix_valid;
    logic [2:0] pix_color;

    logic [2:0] mem [0:255];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = '0;
    logic [2:0] bd_data = '0;

    int chk = 0;
    int fail = 0;

    tetris_board_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .de          (de),
        .active_x    (active_x),
        .active_y    (active_y),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_col    (game_col),
        .game_row    (game_row),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rdata  (game_rdata),
        .game_rvalid (game_rvalid),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .pix_valid   (pix_valid),
        .pix_color   (pix_color)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input int d);
        bd_we = 1'b1; bd_addr = 8'(a); bd_data = 3'(d);
        next_cycle();
        bd_we = 1'b0;
    endtask

    task automatic idle_inputs();
        de = 1'b0; active_x = '0; active_y = '0;
        game_req = 1'b0; game_we = 1'b0; game_col = '0; game_row = '0; game_wdata = '0;
    endtask

    task automatic test_reset();
        de = 1'b1; active_x = 10'(ORG_X); active_y = 10'(ORG_Y);
        game_req = 1'b1; game_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== 15'd0) begin fail++;
                $display("FAIL reset_ram: got en=%0b we=%0b addr=%0d wd=%0d required 0", ram_en, ram_we, ram_addr, ram_wdata); end
            chk++; if ({game_gnt, game_rvalid, game_rdata, pix_valid, pix_color} !== 9'd0) begin fail++;
                $display("FAIL reset_out: got gnt=%0b rv=%0b rd=%0d pv=%0b pc=%0d required 0", game_gnt, game_rvalid, game_rdata, pix_valid, pix_color); end
            next_cycle();
        end
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_display_read();
        for (int k = 0; k < 20; k++) begin
            de = (k <= 16); active_x = 10'(ORG_X + 32 + k); active_y = 10'(ORG_Y + 48);
            @(negedge clk);
            if (k == 0) begin
                chk++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'd32}) begin fail++;
                    $display("FAIL disp_fetch: got en=%0b we=%0b addr=%0d required en=1 we=0 addr=32", ram_en, ram_we, ram_addr); end
            end
            if (k == 1) begin
                chk++; if (ram_en !== 1'b0) begin fail++;
                    $display("FAIL disp_nofetch: got en=%0b required 0", ram_en); end
                chk++; if (pix_valid !== 1'b0) begin fail++;
                    $display("FAIL disp_prevalid: got %0b required 0", pix_valid); end
            end
            if (k == 16) begin
                chk++; if ({ram_en, ram_addr} !== {1'b1, 8'd33}) begin fail++;
                    $display("FAIL disp_fetch2: got en=%0b addr=%0d required en=1 addr=33", ram_en, ram_addr); end
            end
            if (k >= 2 && k <= 17) begin
                chk++; if ({pix_valid, pix_color} !== {1'b1, 3'd5}) begin fail++;
                    $display("FAIL disp_pix%0d: got v=%0b c=%0d required v=1 c=5", k - 2, pix_valid, pix_color); end
            end
            if (k == 18) begin
                chk++; if ({pix_valid, pix_color} !== {1'b1, 3'd2}) begin fail++;
                    $display("FAIL disp_nextcell: got v=%0b c=%0d required v=1 c=2", pix_valid, pix_color); end
            end
            if (k == 19) begin
                chk++; if ({pix_valid, pix_color} !== 4'd0) begin fail++;
                    $display("FAIL disp_blank: got v=%0b c=%0d required v=0 c=0", pix_valid, pix_color); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_window_edges();
        int xs [4] = '{ORG_X + 144, ORG_X + 160, ORG_X,       ORG_X - 16};
        int ys [4] = '{ORG_Y + 304, ORG_Y,       ORG_Y + 320, ORG_Y};
        logic [8:0] exp [4] = '{{1'b1, 8'd199}, 9'd0, 9'd0, 9'd0};
        for (int k = 0; k < 4; k++) begin
            de = 1'b1; active_x = 10'(xs[k]); active_y = 10'(ys[k]);
            @(negedge clk);
            chk++; if ({ram_en, ram_addr} !== exp[k]) begin fail++;
                $display("FAIL edge%0d: got en=%0b addr=%0d required %0h", k, ram_en, ram_addr, exp[k]); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_collision();
        for (int k = 0; k < 4; k++) begin
            de = (k < 3); active_y = 10'(ORG_Y); active_x = 10'(ORG_X + 15 + k);
            game_req = (k < 3); game_we = 1'b1; game_col = 4'd0; game_row = 5'd0; game_wdata = 3'd7;
            @(negedge clk);
            if (k == 0 || k == 3) begin
                chk++; if (game_gnt !== 1'b0) begin fail++;
                    $display("FAIL coll_nognt%0d: got %0b required 0", k, game_gnt); end
            end
            if (k == 1) begin
                chk++; if ({game_gnt, ram_en, ram_we, ram_addr} !== {3'b010, 8'd1}) begin fail++;
                    $display("FAIL coll_fetchwins: got gnt=%0b en=%0b we=%0b addr=%0d required gnt=0 en=1 we=0 addr=1", game_gnt, ram_en, ram_we, ram_addr); end
            end
            if (k == 2) begin
                chk++; if ({game_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {3'b111, 8'd0, 3'd7}) begin fail++;
                    $display("FAIL coll_gnt: got gnt=%0b en=%0b we=%0b addr=%0d wd=%0d required 1 1 1 0 7", game_gnt, ram_en, ram_we, ram_addr, ram_wdata); end
            end
            if (k == 3) begin
                chk++; if (mem[0] !== 3'd7) begin fail++;
                    $display("FAIL coll_ram: got cell0=%0d required 7", mem[0]); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_game_read();
        for (int k = 0; k < 4; k++) begin
            game_req = (k < 2); game_we = 1'b0; game_col = 4'd9; game_row = 5'd19;
            @(negedge clk);
            if (k == 0) begin
                chk++; if (game_gnt !== 1'b0) begin fail++;
                    $display("FAIL rd_idle: got gnt=%0b required 0", game_gnt); end
            end
            if (k == 1) begin
                chk++; if ({game_gnt, ram_en, ram_we, ram_addr} !== {3'b110, 8'd199}) begin fail++;
                    $display("FAIL rd_gnt: got gnt=%0b en=%0b we=%0b addr=%0d required 1 1 0 199", game_gnt, ram_en, ram_we, ram_addr); end
            end
            if (k == 2) begin
                chk++; if ({game_rvalid, game_rdata} !== {1'b1, 3'd4}) begin fail++;
                    $display("FAIL rd_data: got rv=%0b rd=%0d required rv=1 rd=4", game_rvalid, game_rdata); end
            end
            if (k == 3) begin
                chk++; if ({game_rvalid, game_rdata} !== {1'b0, 3'd4}) begin fail++;
                    $display("FAIL rd_hold: got rv=%0b rd=%0d required rv=0 rd=4", game_rvalid, game_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 3; k++) begin
            game_req = (k < 2); game_we = 1'b1; game_col = 4'd12; game_row = 5'd0; game_wdata = 3'd3;
            @(negedge clk);
            if (k == 1) begin
                chk++; if ({game_gnt, ram_en, ram_we} !== 3'b100) begin fail++;
                    $display("FAIL oor_wr_gnt: got gnt=%0b en=%0b we=%0b required 1 0 0", game_gnt, ram_en, ram_we); end
            end
            if (k == 2) begin
                chk++; if (mem[12] !== 3'd6) begin fail++;
                    $display("FAIL oor_wr_ram: got cell12=%0d required 6", mem[12]); end
            end
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            game_req = (k < 2); game_we = 1'b0; game_col = 4'd0; game_row = 5'd25;
            @(negedge clk);
            if (k == 1) begin
                chk++; if ({game_gnt, ram_en} !== 2'b10) begin fail++;
                    $display("FAIL oor_rd_gnt: got gnt=%0b en=%0b required 1 0", game_gnt, ram_en); end
            end
            if (k == 2) begin
                chk++; if ({game_rvalid, game_rdata} !== {1'b1, 3'd0}) begin fail++;
                    $display("FAIL oor_rd_data: got rv=%0b rd=%0d required rv=1 rd=0", game_rvalid, game_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_blank_grant();
`ifdef BOARD_ARB_BLANK_ONLY_EN
        localparam int GNT_K = 4;
`else
        localparam int GNT_K = 1;
`endif
        for (int k = 0; k <= GNT_K + 1; k++) begin
            de = (k < GNT_K); active_x = '0; active_y = '0;
            game_req = (k <= GNT_K); game_we = 1'b1; game_col = 4'd5; game_row = 5'd5; game_wdata = 3'd2;
            @(negedge clk);
            if (k < GNT_K) begin
                chk++; if (game_gnt !== 1'b0) begin fail++;
                    $display("FAIL blank_wait%0d: got gnt=%0b required 0", k, game_gnt); end
            end
            if (k == GNT_K) begin
                chk++; if ({game_gnt, ram_we, ram_addr} !== {2'b11, 8'd55}) begin fail++;
                    $display("FAIL blank_gnt: got gnt=%0b we=%0b addr=%0d required 1 1 55", game_gnt, ram_we, ram_addr); end
            end
            if (k == GNT_K + 1) begin
                chk++; if (mem[55] !== 3'd2) begin fail++;
                    $display("FAIL blank_ram: got cell55=%0d required 2", mem[55]); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        game_req = 1'b1; game_we = 1'b0; game_col = 4'd0; game_row = 5'd0;
        next_cycle();
        @(negedge clk);
        chk++; if (game_gnt !== 1'b1) begin fail++;
            $display("FAIL rst_pre_gnt: got %0b required 1", game_gnt); end
        next_cycle();
        game_req = 1'b0;
        #1;
        chk++; if ({game_rvalid, game_rdata} !== {1'b1, 3'd7}) begin fail++;
            $display("FAIL rst_pre_rv: got rv=%0b rd=%0d required rv=1 rd=7", game_rvalid, game_rdata); end
        rst_n = 1'b0;
        #1;
        chk++; if ({game_rvalid, game_rdata, game_gnt, ram_en, ram_we, pix_valid, pix_color} !== 10'd0) begin fail++;
            $display("FAIL rst_mid_out: got rv=%0b rd=%0d gnt=%0b en=%0b we=%0b pv=%0b pc=%0d required 0", game_rvalid, game_rdata, game_gnt, ram_en, ram_we, pix_valid, pix_color); end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk++; if ({game_rvalid, game_gnt, game_rdata} !== 5'd0) begin fail++;
                $display("FAIL rst_post%0d: got rv=%0b gnt=%0b rd=%0d required 0", k, game_rvalid, game_gnt, game_rdata); end
            next_cycle();
        end
    endtask

    initial begin
        next_cycle();
        poke(32, 5);
        poke(33, 2);
        poke(0, 1);
        poke(199, 4);
        poke(12, 6);
        poke(55, 0);
        test_reset();
        test_display_read();
        test_window_edges();
        test_collision();
        test_game_read();
        test_out_of_range();
        test_blank_grant();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
        $finish;
    end

endmodule
